// File: rtl/seven_seg_scanner.sv
// Eight-digit multiplexed seven-segment scanner with shadow/active digit buffers.
// Define LEADING_ZERO_BLANK_EN to also darken leading zero digits (7 downward).
module seven_seg_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset_clk,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       wr_blank,
    input  logic       commit,
    output logic       commit_pending,
    output logic       frame_done,
    output logic [7:0] AN,
    output logic [6:0] C
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] refresh_cnt;
    logic [2:0]    index;
    logic [4:0]    shadow [8];
    logic [4:0]    active [8];
    logic          pending;
    logic          tc;
    logic          wrap;
    logic          copy;
    logic [7:0]    suppress;
    logic [4:0]    slot;
    logic          dark;

    assign tc             = (refresh_cnt == LAST);
    assign wrap           = tc && (index == 3'd7);
    assign copy           = wrap && pending;
    assign commit_pending = pending;

    always_ff @(posedge clk or negedge reset_clk) begin
        if (!reset_clk) begin
            refresh_cnt <= '0;
            index       <= '0;
        end else if (tc) begin
            refresh_cnt <= '0;
            index       <= index + 3'd1;
        end else begin
            refresh_cnt <= refresh_cnt + CW'(1);
        end
    end

    // The copy reads shadow before this edge's write lands, so a coincident write stays in shadow.
    always_ff @(posedge clk or negedge reset_clk) begin
        if (!reset_clk) begin
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= 5'h10;
                active[i] <= 5'h10;
            end
        end else begin
            if (copy) begin
                for (int i = 0; i < 8; i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (wr_en) begin
                shadow[wr_addr] <= {wr_blank, wr_data};
            end
        end
    end

    // A commit on the copy edge wins, so it carries into the next frame.
    always_ff @(posedge clk or negedge reset_clk) begin
        if (!reset_clk) begin
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (commit) begin
                pending <= 1'b1;
            end else if (copy) begin
                pending <= 1'b0;
            end
            frame_done <= wrap;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic run;

    always_comb begin
        suppress = 8'h00;
        run      = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            if (run && !active[i][4] && (active[i][3:0] == 4'h0)) begin
                suppress[i] = 1'b1;
            end else begin
                run = 1'b0;
            end
        end
    end
`else
    assign suppress = 8'h00;
`endif

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        g = 7'h7F;
        case (v)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h58;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            4'hF: g = 7'h0E;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    always_comb begin
        slot = active[index];
        dark = slot[4] | suppress[index];
    end

    always_ff @(posedge clk or negedge reset_clk) begin
        if (!reset_clk) begin
            AN <= 8'hFF;
            C  <= 7'h7F;
        end else begin
            AN <= dark ? 8'hFF : ~(8'h01 << index);
            C  <= dark ? 7'h7F : glyph(slot[3:0]);
        end
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: glyph table, directed corner sequences,
// and randomized traffic against a time-based reference model.
module tb_seven_seg_scanner;
    localparam int DIV   = 4;
    localparam int FRAME = 8 * DIV;

    typedef struct {
        logic [3:0] value;
        logic [6:0] glyph;
    } glyph_vec_t;

    logic       clk;
    logic       reset_clk;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_blank;
    logic       commit;
    logic       commit_pending;
    logic       frame_done;
    logic [7:0] AN;
    logic [6:0] C;

    int checks;
    int errors;

    glyph_vec_t vecs [16];
    logic [4:0] m_shadow [8];
    logic [4:0] m_active [8];
    bit         m_pending;
    int         k;
    logic [7:0] exp_an;
    logic [6:0] exp_c;
    bit         exp_fd;
    bit         exp_cp;

    seven_seg_scanner #(.REFRESH_DIV(DIV)) dut (
        .clk            (clk),
        .reset_clk      (reset_clk),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_blank       (wr_blank),
        .commit         (commit),
        .commit_pending (commit_pending),
        .frame_done     (frame_done),
        .AN             (AN),
        .C              (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h (edge %0d)", name, act, exp, k);
        end
    endtask

    function automatic bit leadingZero(input int idx);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 0) return 1'b0;
        for (int j = idx; j < 8; j++) begin
            if (m_active[j][4] || (m_active[j][3:0] != 4'h0)) return 1'b0;
        end
        return 1'b1;
`else
        return (idx < 0);
`endif
    endfunction

    task automatic modelReset();
        k = 0;
        for (int i = 0; i < 8; i++) begin
            m_shadow[i] = 5'h10;
            m_active[i] = 5'h10;
        end
        m_pending = 1'b0;
        exp_an = 8'hFF;
        exp_c  = 7'h7F;
        exp_fd = 1'b0;
        exp_cp = 1'b0;
    endtask

    // Edge number k+1: the digit on show is fixed purely by elapsed time since reset.
    task automatic modelEdge();
        int idx;
        bit boundary;
        bit copy;
        bit dark;
        logic [4:0] cur;
        idx      = (k / DIV) % 8;
        boundary = (k % FRAME) == (FRAME - 1);
        cur      = m_active[idx];
        dark     = cur[4] || leadingZero(idx);
        exp_an   = dark ? 8'hFF : ~(8'h01 << idx);
        exp_c    = dark ? 7'h7F : vecs[cur[3:0]].glyph;
        exp_fd   = boundary;
        copy     = boundary && m_pending;
        if (copy) begin
            for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
        end
        if (wr_en) m_shadow[wr_addr] = {wr_blank, wr_data};
        if (commit) m_pending = 1'b1;
        else if (copy) m_pending = 1'b0;
        exp_cp = m_pending;
        k++;
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput("model_AN", AN, exp_an);
        checkOutput("model_C", {1'b0, C}, {1'b0, exp_c});
        checkOutput("model_commit_pending", {7'd0, commit_pending}, {7'd0, exp_cp});
        checkOutput("model_frame_done", {7'd0, frame_done}, {7'd0, exp_fd});
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] addr, input logic [3:0] data,
                                 input logic blank, input logic cm);
        wr_en    = we;
        wr_addr  = addr;
        wr_data  = data;
        wr_blank = blank;
        commit   = cm;
        step();
        wr_en  = 1'b0;
        commit = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic waitEdgePhase(input int phase);
        for (int n = 0; n < FRAME + 2 && (k % FRAME) != phase; n++) step();
        checkOutput("phase_reached", 8'((k % FRAME) == phase), 8'd1);
    endtask

    // After the edge that registers digit d from the current frame.
    task automatic waitSlot(input int d);
        waitEdgePhase((d * DIV + 1) % FRAME);
    endtask

    task automatic waitCopy();
        for (int n = 0; n < 2 * FRAME + 2 && commit_pending; n++) step();
        checkOutput("copy_timeout", {7'd0, commit_pending}, 8'd0);
    endtask

    task automatic doReset(input int n);
        reset_clk = 1'b0;
        wr_en = 1'b0;
        commit = 1'b0;
        #1;
        checkOutput("reset_AN", AN, 8'hFF);
        checkOutput("reset_C", {1'b0, C}, 8'h7F);
        checkOutput("reset_commit_pending", {7'd0, commit_pending}, 8'd0);
        checkOutput("reset_frame_done", {7'd0, frame_done}, 8'd0);
        repeat (n) @(negedge clk);
        reset_clk = 1'b1;
        modelReset();
    endtask

    initial begin
        int gap;
        vecs[0]  = '{4'h0, 7'h40}; vecs[1]  = '{4'h1, 7'h79};
        vecs[2]  = '{4'h2, 7'h24}; vecs[3]  = '{4'h3, 7'h30};
        vecs[4]  = '{4'h4, 7'h19}; vecs[5]  = '{4'h5, 7'h12};
        vecs[6]  = '{4'h6, 7'h02}; vecs[7]  = '{4'h7, 7'h58};
        vecs[8]  = '{4'h8, 7'h00}; vecs[9]  = '{4'h9, 7'h10};
        vecs[10] = '{4'hA, 7'h08}; vecs[11] = '{4'hB, 7'h03};
        vecs[12] = '{4'hC, 7'h46}; vecs[13] = '{4'hD, 7'h21};
        vecs[14] = '{4'hE, 7'h06}; vecs[15] = '{4'hF, 7'h0E};
        checks = 0;
        errors = 0;
        wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'h0; wr_blank = 1'b0; commit = 1'b0;
        k = 0;

        // Power-on reset held for three cycles; first frame must stay dark.
        @(negedge clk);
        doReset(3);
        for (int i = 0; i < FRAME; i++) begin
            step();
            checkOutput("first_frame_dark", AN, 8'hFF);
        end

        // Write 1..8 into digits 0..7 and commit.
        for (int d = 0; d < 8; d++) applyStimulus(1'b1, 3'(d), 4'(d + 1), 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd0, 4'h0, 1'b0, 1'b1);
        checkOutput("commit_pending_set", {7'd0, commit_pending}, 8'd1);
        waitCopy();
        checkOutput("copy_at_wrap_frame_done", {7'd0, frame_done}, 8'd1);
        waitSlot(0);
        checkOutput("digit0_AN", AN, 8'hFE);
        checkOutput("digit0_C", {1'b0, C}, 8'h79);
        waitSlot(7);
        checkOutput("digit7_AN", AN, 8'h7F);
        checkOutput("digit7_C", {1'b0, C}, 8'h00);

        // Write on the copy edge stays in shadow only.
        applyStimulus(1'b0, 3'd0, 4'h0, 1'b0, 1'b1);
        waitEdgePhase(FRAME - 1);
        applyStimulus(1'b1, 3'd3, 4'hF, 1'b0, 1'b0);
        checkOutput("boundary_copy_done", {7'd0, commit_pending}, 8'd0);
        waitSlot(3);
        checkOutput("boundary_old_glyph", {1'b0, C}, 8'h19);
        applyStimulus(1'b0, 3'd0, 4'h0, 1'b0, 1'b1);
        waitCopy();
        waitSlot(3);
        checkOutput("boundary_new_glyph", {1'b0, C}, 8'h0E);

        // Commit on the wrap edge itself waits for the following frame.
        waitEdgePhase(FRAME - 1);
        applyStimulus(1'b0, 3'd0, 4'h0, 1'b0, 1'b1);
        checkOutput("late_commit_pending", {7'd0, commit_pending}, 8'd1);
        waitCopy();

        // Blanked digit 2 and frame_done cadence.
        applyStimulus(1'b1, 3'd2, 4'h5, 1'b1, 1'b1);
        waitCopy();
        waitSlot(2);
        checkOutput("blank_AN", AN, 8'hFF);
        checkOutput("blank_C", {1'b0, C}, 8'h7F);
        for (int n = 0; n < FRAME + 2 && !frame_done; n++) step();
        gap = 0;
        do begin
            step();
            gap++;
        end while (!frame_done && gap < FRAME + 4);
        checkOutput("frame_done_period", 8'(gap), 8'(FRAME));

        // Leading zeros: digits 7..0 = 0,0,0,0,0,0,4,0.
        for (int d = 0; d < 8; d++) applyStimulus(1'b1, 3'(d), (d == 1) ? 4'h4 : 4'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd0, 4'h0, 1'b0, 1'b1);
        waitCopy();
        waitSlot(7);
`ifdef LEADING_ZERO_BLANK_EN
        checkOutput("lzb_digit7_AN", AN, 8'hFF);
        checkOutput("lzb_digit7_C", {1'b0, C}, 8'h7F);
`else
        checkOutput("zero_digit7_AN", AN, 8'h7F);
        checkOutput("zero_digit7_C", {1'b0, C}, 8'h40);
`endif
        waitSlot(1);
        checkOutput("lz_digit1_C", {1'b0, C}, 8'h19);
        waitSlot(0);
        checkOutput("lz_digit0_C", {1'b0, C}, 8'h40);

        // Two commits five cycles apart: one copy, one fall of commit_pending.
        waitEdgePhase(2);
        applyStimulus(1'b0, 3'd0, 4'h0, 1'b0, 1'b1);
        idle(4);
        applyStimulus(1'b1, 3'd5, 4'h9, 1'b0, 1'b1);
        checkOutput("double_commit_pending", {7'd0, commit_pending}, 8'd1);
        waitCopy();
        checkOutput("double_commit_fall_at_wrap", {7'd0, frame_done}, 8'd1);
        idle(FRAME);

        // Glyph table through digit 0.
        for (int v = 0; v < 16; v++) begin
            applyStimulus(1'b1, 3'd0, vecs[v].value, 1'b0, 1'b1);
            waitCopy();
            waitSlot(0);
            checkOutput("glyph_table", {1'b0, C}, {1'b0, vecs[v].glyph});
        end

        // Reset mid-frame discards a pending commit.
        applyStimulus(1'b1, 3'd4, 4'h7, 1'b0, 1'b1);
        idle(3);
        doReset(2);
        for (int i = 0; i < FRAME + 4; i++) step();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 4) == 0),
                          1'($urandom_range(0, 24) == 0));
        end
        idle(2 * FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
